// File: rtl/sw_seq_pkg.sv
// Shared types and constants for the switch-sweep self-test sequencer.
// Holds the FSM state encoding, code count and settle counter width.
package sw_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        WAIT
    } state_t;

    localparam int N_SW_DEF   = 3;
    localparam int N_LED_DEF  = 4;
    localparam int N_CODES    = 2 ** N_SW_DEF;
    localparam int CNT_W      = $clog2(256);
    localparam int SETTLE_DEF = 4;

endpackage

// File: rtl/sw_seq_ctrl_if.sv
// Control and result bus between board buttons and the sweep sequencer.
// master drives requests and reads results; slave is the sequencer.
interface sw_seq_ctrl_if import sw_seq_pkg::*; #(
    parameter int N_SW  = N_SW_DEF,
    parameter int N_LED = N_LED_DEF
) ();

    logic             start;
    logic             manual;
    logic             step;
    logic             abort;
    logic             busy;
    logic             cap_valid;
    logic [N_SW-1:0]  cap_code;
    logic [N_LED-1:0] cap_led;
    logic             done;

    modport master (
        output start, manual, step, abort,
        input  busy, cap_valid, cap_code, cap_led, done
    );

    modport slave (
        input  start, manual, step, abort,
        output busy, cap_valid, cap_code, cap_led, done
    );

endinterface

// File: rtl/sw_seq_settle_timer.sv
// Down-counter that times how long a switch code is held before sampling.
// Loads a start value, counts down on tick and parks at zero.
module sw_seq_settle_timer import sw_seq_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over countdown; the count never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sw_seq_ctrl.sv
// Self-test sequencer: sweeps switch codes 0..2**N_SW-1, captures LEDs.
// Optional expected-value checking is built when SEQ_CHECK_EN is defined.
module sw_seq_ctrl import sw_seq_pkg::*; #(
    parameter int SETTLE_CYCLES = SETTLE_DEF,
    parameter int N_SW          = N_SW_DEF,
    parameter int N_LED         = N_LED_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    sw_seq_ctrl_if.slave                 bus,
    output logic [N_SW-1:0]              sw_out,
    input  logic [N_LED-1:0]             led_in
`ifdef SEQ_CHECK_EN
    ,
    input  logic [N_LED*(2**N_SW)-1:0]   exp_table,
    output logic [(2**N_SW)-1:0]         err_mask,
    output logic                         pass
`endif
);

    localparam int              CODES  = 2 ** N_SW;
    localparam logic [N_SW-1:0] LAST   = N_SW'(CODES - 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [N_SW-1:0]  code;
    logic [N_SW-1:0]  sw_q;
    logic             manual_q;
    logic             cap_valid_q;
    logic             done_q;
    logic [N_SW-1:0]  cap_code_q;
    logic [N_LED-1:0] cap_led_q;

    logic             abort_act;
    logic             accept;
    logic             last;
    logic             advance;
    logic [N_SW-1:0]  nxt_code;
    logic             tmr_load;
    logic             tmr_tick;
    logic             tmr_zero;

    assign abort_act = bus.abort && (state != IDLE);
    assign accept    = (state == IDLE) && bus.start;
    assign last      = (code == LAST);
    assign nxt_code  = code + 1'b1;
    assign advance   = !abort_act &&
                       (((state == CAPTURE) && !last && !manual_q) ||
                        ((state == WAIT) && bus.step));
    assign tmr_load  = accept || advance;
    assign tmr_tick  = (state == SETTLE);

    sw_seq_settle_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .tick  (tmr_tick),
        .value (RELOAD),
        .zero  (tmr_zero)
    );

    // Sweep FSM; abort overrides every other action outside IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            code        <= '0;
            sw_q        <= '0;
            manual_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cap_code_q  <= '0;
            cap_led_q   <= '0;
        end else begin
            cap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (abort_act) begin
                state <= IDLE;
                code  <= '0;
                sw_q  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            code     <= '0;
                            sw_q     <= '0;
                            manual_q <= bus.manual;
                            state    <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (tmr_zero) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        cap_led_q   <= led_in;
                        cap_code_q  <= code;
                        cap_valid_q <= 1'b1;
                        if (last) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else if (!manual_q) begin
                            code  <= nxt_code;
                            sw_q  <= nxt_code;
                            state <= SETTLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.step) begin
                            code  <= nxt_code;
                            sw_q  <= nxt_code;
                            state <= SETTLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sw_out        = sw_q;
    assign bus.busy      = (state != IDLE);
    assign bus.cap_valid = cap_valid_q;
    assign bus.cap_code  = cap_code_q;
    assign bus.cap_led   = cap_led_q;
    assign bus.done      = done_q;

`ifdef SEQ_CHECK_EN
    logic [N_LED-1:0] exp_led;
    logic             mis;
    logic [CODES-1:0] err_q;
    logic             pass_q;

    assign exp_led = exp_table[N_LED*code +: N_LED];
    assign mis     = (led_in != exp_led);

    // Per-code mismatch flags; pass summarises the sweep at the done edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else if ((state == CAPTURE) && !abort_act) begin
            err_q[code] <= mis;
            if (last) begin
                pass_q <= !mis && (err_q == '0);
            end
        end
    end

    assign err_mask = err_q;
    assign pass     = pass_q;
`endif

endmodule

// File: tb/tb_sw_seq_ctrl.sv
// Directed bench for sw_seq_ctrl with a sw->led schematic model.
// Checking tests run when SEQ_CHECK_EN is defined for the build.
module tb_sw_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw_out;
    logic [3:0] led_in;
    int         total = 0;
    int         bad = 0;

    sw_seq_ctrl_if #(.N_SW(3), .N_LED(4)) bus ();

`ifdef SEQ_CHECK_EN
    logic [31:0] exp_table;
    logic [7:0]  err_mask;
    logic        pass;
`endif

    sw_seq_ctrl #(.SETTLE_CYCLES(4), .N_SW(3), .N_LED(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sw_out    (sw_out),
        .led_in    (led_in)
`ifdef SEQ_CHECK_EN
        ,
        .exp_table (exp_table),
        .err_mask  (err_mask),
        .pass      (pass)
`endif
    );

    always #5 clk = ~clk;

    assign led_in = {1'b0, sw_out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cap(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.cap_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.manual = 1'b0;
        bus.step = 1'b0;
        bus.abort = 1'b0;
        #12;
        total++;
        if ({sw_out, bus.busy, bus.cap_valid, bus.cap_code,
             bus.cap_led, bus.done} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {sw_out, bus.busy,
                     bus.cap_valid, bus.cap_code, bus.cap_led, bus.done});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b0 || sw_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle busy=%b sw=%0d exp busy=0 sw=0",
                     bus.busy, sw_out);
        end
    endtask

    task automatic test_auto();
        int exp_sw;
        logic exp_cv;
        bus.manual = 1'b0;
        bus.start = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            bus.start = 1'b0;
            exp_sw = (n - 1) / 5;
            if (exp_sw > 7) exp_sw = 7;
            exp_cv = (n >= 6) && (n <= 41) && ((n - 1) % 5 == 0);
            total++;
            if (sw_out !== 3'(exp_sw)) begin
                bad++;
                $display("FAIL auto_sw cyc=%0d got=%0d exp=%0d", n, sw_out, exp_sw);
            end
            total++;
            if (bus.cap_valid !== exp_cv) begin
                bad++;
                $display("FAIL auto_cv cyc=%0d got=%b exp=%b", n, bus.cap_valid, exp_cv);
            end
            if (exp_cv) begin
                total++;
                if (bus.cap_code !== 3'((n - 6) / 5) ||
                    bus.cap_led !== 4'((n - 6) / 5)) begin
                    bad++;
                    $display("FAIL auto_cap cyc=%0d code=%0d led=%0d exp=%0d",
                             n, bus.cap_code, bus.cap_led, (n - 6) / 5);
                end
            end
            total++;
            if (bus.done !== (n == 41)) begin
                bad++;
                $display("FAIL auto_done cyc=%0d got=%b exp=%b", n, bus.done, n == 41);
            end
            total++;
            if (bus.busy !== (n < 41)) begin
                bad++;
                $display("FAIL auto_busy cyc=%0d got=%b exp=%b", n, bus.busy, n < 41);
            end
        end
    endtask

    task automatic test_manual();
        int n;
        bus.manual = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        total++;
        if (sw_out !== 3'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL man_step_settle sw=%0d busy=%b exp sw=0 busy=1",
                     sw_out, bus.busy);
        end
        wait_cap(10, n);
        total++;
        if (n != 3 || bus.cap_code !== 3'd0 || bus.cap_led !== 4'd0) begin
            bad++;
            $display("FAIL man_cap0 wait=%0d code=%0d exp wait=3 code=0",
                     n, bus.cap_code);
        end
        for (int k = 0; k < 7; k++) begin
            tick();
            tick();
            total++;
            if (sw_out !== 3'(k) || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL man_hold k=%0d sw=%0d busy=%b", k, sw_out, bus.busy);
            end
            tick();
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            total++;
            if (sw_out !== 3'(k + 1)) begin
                bad++;
                $display("FAIL man_adv got=%0d exp=%0d", sw_out, k + 1);
            end
            wait_cap(10, n);
            total++;
            if (n != 5 || bus.cap_code !== 3'(k + 1) ||
                bus.cap_led !== 4'(k + 1) || bus.done !== (k == 6)) begin
                bad++;
                $display("FAIL man_cap wait=%0d code=%0d done=%b exp code=%0d",
                         n, bus.cap_code, bus.done, k + 1);
            end
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL man_end_busy got=%b exp=0", bus.busy);
        end
        tick();
        total++;
        if (bus.cap_valid !== 1'b0 || sw_out !== 3'd7) begin
            bad++;
            $display("FAIL man_idle cv=%b sw=%0d exp cv=0 sw=7", bus.cap_valid, sw_out);
        end
        bus.manual = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        logic seen;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 2; i <= 17; i++) tick();
        total++;
        if (sw_out !== 3'd3) begin
            bad++;
            $display("FAIL abort_pre_sw got=%0d exp=3", sw_out);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || sw_out !== 3'd0 ||
            bus.cap_valid !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_now busy=%b sw=%0d cv=%b done=%b exp all 0",
                     bus.busy, sw_out, bus.cap_valid, bus.done);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cap_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
                seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_quiet got=activity exp=none");
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_cap(10, n);
        total++;
        if (n != 5 || bus.cap_code !== 3'd0) begin
            bad++;
            $display("FAIL abort_restart wait=%0d code=%0d exp wait=5 code=0",
                     n, bus.cap_code);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || sw_out !== 3'd0) begin
            bad++;
            $display("FAIL abort_again busy=%b sw=%0d exp 0", bus.busy, sw_out);
        end
    endtask

    task automatic test_async_rst();
        logic seen;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 2; i <= 15; i++) tick();
        total++;
        if (bus.cap_code !== 3'd1 || bus.cap_led !== 4'd1 || sw_out !== 3'd2) begin
            bad++;
            $display("FAIL rst_pre code=%0d led=%0d sw=%0d exp 1 1 2",
                     bus.cap_code, bus.cap_led, sw_out);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({sw_out, bus.busy, bus.cap_valid, bus.cap_code,
             bus.cap_led, bus.done} !== 13'd0) begin
            bad++;
            $display("FAIL rst_async got=%b exp=0", {sw_out, bus.busy,
                     bus.cap_valid, bus.cap_code, bus.cap_led, bus.done});
        end
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cap_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_after got=activity exp=none");
        end
    endtask

    task automatic test_back_to_back();
        int caps;
        int dones;
        int last_cyc;
        int last_code;
        caps = 0;
        dones = 0;
        last_cyc = -1;
        last_code = -1;
        bus.start = 1'b1;
        bus.step = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            bus.start = 1'b0;
            bus.step = 1'b0;
            if (bus.cap_valid === 1'b1) begin
                caps++;
                last_cyc = n;
                last_code = int'(bus.cap_code);
            end
            if (bus.done === 1'b1) dones++;
            if (n == 3 || n == 20 || n == 40) bus.start = 1'b1;
        end
        total++;
        if (caps != 8 || dones != 1) begin
            bad++;
            $display("FAIL b2b_count caps=%0d dones=%0d exp 8 1", caps, dones);
        end
        total++;
        if (last_cyc != 41 || last_code != 7 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_last cyc=%0d code=%0d busy=%b exp 41 7 0",
                     last_cyc, last_code, bus.busy);
        end
    endtask

`ifdef SEQ_CHECK_EN
    task automatic test_check(input bit with_err);
        int n;
        for (int k = 0; k < 8; k++) exp_table[4*k +: 4] = 4'(k);
        if (with_err) exp_table[20 +: 4] = 4'hA;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (pass !== 1'b0 || err_mask !== 8'h00) begin
            bad++;
            $display("FAIL chk_clear pass=%b mask=%b exp 0", pass, err_mask);
        end
        n = -1;
        for (int i = 2; i <= 50; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        total++;
        if (n != 41) begin
            bad++;
            $display("FAIL chk_done cyc=%0d exp=41", n);
        end
        total++;
        if (with_err && (err_mask !== 8'b0010_0000 || pass !== 1'b0)) begin
            bad++;
            $display("FAIL chk_err mask=%b pass=%b exp 00100000 0", err_mask, pass);
        end else if (!with_err && (err_mask !== 8'h00 || pass !== 1'b1)) begin
            bad++;
            $display("FAIL chk_ok mask=%b pass=%b exp 00000000 1", err_mask, pass);
        end
        tick();
        tick();
    endtask
`endif

    initial begin
`ifdef SEQ_CHECK_EN
        exp_table = '0;
`endif
        test_reset();
        test_auto();
        total++;
        if (sw_out !== 3'd7 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL auto_idle_sw got=%0d busy=%b exp 7 0", sw_out, bus.busy);
        end
        test_manual();
        test_abort();
        test_async_rst();
        test_back_to_back();
`ifdef SEQ_CHECK_EN
        test_check(1'b1);
        test_check(1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
